// File: rtl/chess_pkg.sv
// Shared chess definitions for the board memory datapath.
//   - piece codes: 0 empty, black 1..6 (P N B R Q K), white 7..12
//   - board_writer FSM state encoding
//   - square type and the {y,x} address mapping shared with address_encoder
package chess_pkg;

  localparam int BOARD_W = 8;

  localparam logic [3:0] EMPTY    = 4'd0;
  localparam logic [3:0] B_PAWN   = 4'd1;
  localparam logic [3:0] B_KNIGHT = 4'd2;
  localparam logic [3:0] B_BISHOP = 4'd3;
  localparam logic [3:0] B_ROOK   = 4'd4;
  localparam logic [3:0] B_QUEEN  = 4'd5;
  localparam logic [3:0] B_KING   = 4'd6;
  localparam logic [3:0] W_PAWN   = 4'd7;
  localparam logic [3:0] W_KNIGHT = 4'd8;
  localparam logic [3:0] W_BISHOP = 4'd9;
  localparam logic [3:0] W_ROOK   = 4'd10;
  localparam logic [3:0] W_QUEEN  = 4'd11;
  localparam logic [3:0] W_KING   = 4'd12;

  // white code = black code + COLOR_OFS
  localparam logic [3:0] COLOR_OFS = W_PAWN - B_PAWN;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_RD_SRC = 3'd2;
  localparam logic [2:0] S_RD_DST = 3'd3;
  localparam logic [2:0] S_WR_DST = 3'd4;
  localparam logic [2:0] S_WR_SRC = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } square_t;

  function automatic logic [5:0] sq_addr(input square_t s);
    return {s.y, s.x};
  endfunction

endpackage

// File: rtl/board_writer_if.sv
// Bundle between board_writer and its neighbours.
//   control side : init_req, move_req, src_x/src_y, dst_x/dst_y -> writer
//                  busy, done, captured, error               <- writer
//   memory side  : address, data_out, write_en                <- writer
//                  rd_data                                    -> writer
// slave  : the writer itself
// master : control plus memory_access (or a testbench standing in for both)
interface board_writer_if;
  logic       init_req;
  logic       move_req;
  logic [3:0] src_x;
  logic [3:0] src_y;
  logic [3:0] dst_x;
  logic [3:0] dst_y;
  logic       busy;
  logic       done;
  logic [3:0] captured;
  logic       error;
  logic [5:0] address;
  logic [3:0] data_out;
  logic       write_en;
  logic [3:0] rd_data;

  modport slave (
    input  init_req, move_req, src_x, src_y, dst_x, dst_y, rd_data,
    output busy, done, captured, error, address, data_out, write_en
  );

  modport master (
    output init_req, move_req, src_x, src_y, dst_x, dst_y, rd_data,
    input  busy, done, captured, error, address, data_out, write_en
  );
endinterface

// File: rtl/board_writer_init_rom.sv
// init_rom: combinational starting-position table.
//   addr  in  6  square address {y[2:0], x[2:0]}
//   piece out 4  piece code on that square in the standard opening setup
// Black occupies ranks 0/1, white ranks 6/7; also usable as a VGA test pattern.
module init_rom
  import chess_pkg::*;
(
  input  logic [5:0] addr,
  output logic [3:0] piece
);

  logic [3:0] back_rank;

  // black back rank R N B Q K B N R; white uses the same files offset by colour
  always_comb begin
    back_rank = B_ROOK;
    case (addr[2:0])
      3'd0, 3'd7: back_rank = B_ROOK;
      3'd1, 3'd6: back_rank = B_KNIGHT;
      3'd2, 3'd5: back_rank = B_BISHOP;
      3'd3:       back_rank = B_QUEEN;
      default:    back_rank = B_KING;
    endcase
  end

  always_comb begin
    piece = EMPTY;
    case (addr[5:3])
      3'd0:    piece = back_rank;
      3'd1:    piece = B_PAWN;
      3'd6:    piece = W_PAWN;
      3'd7:    piece = back_rank + COLOR_OFS;
      default: piece = EMPTY;
    endcase
  end

endmodule

// File: rtl/board_writer.sv
// board_writer: write-side engine for the 64-square board memory.
//   clk    in  system clock
//   reset  in  asynchronous, active-low
//   bus    slave modport of board_writer_if
//            init_req/move_req + coordinates in, busy/done/captured/error out,
//            address/data_out/write_en out, rd_data in
// Jobs: fill the board with the starting position (64 cycles, one write each)
// or commit a move as read src, read dst, write dst, clear src.
// MEM_RD_LAT (1 or 2) is the synchronous RAM read latency in cycles.
// Build option: define PROMOTION_EN to turn a pawn reaching the last rank
// into a queen of its colour when written to the destination.
module board_writer
  import chess_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  board_writer_if.slave  bus
);

  localparam logic [1:0] RD_WAIT = 2'(MEM_RD_LAT);

  logic [2:0] state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [3:0] cap_q, cap_d;
  logic [3:0] piece_q, piece_d;
  logic [1:0] wait_q, wait_d;
  square_t    src_q, src_d;
  square_t    dst_q, dst_d;

  logic [5:0] rom_addr;
  logic [3:0] rom_piece;
  logic [3:0] wr_piece;
  logic       bad_move;

  // address_q doubles as the fill counter, so the ROM looks one square ahead
  assign rom_addr = (state_q == S_INIT) ? addr_q + 6'd1 : 6'd0;

  init_rom u_rom (
    .addr  (rom_addr),
    .piece (rom_piece)
  );

  // any coordinate with bit 3 set is off the 8x8 board
  assign bad_move = bus.src_x[3] | bus.src_y[3] | bus.dst_x[3] | bus.dst_y[3] |
                    ((bus.src_x == bus.dst_x) && (bus.src_y == bus.dst_y));

`ifdef PROMOTION_EN
  always_comb begin
    wr_piece = piece_q;
    if (piece_q == B_PAWN && dst_q.y == 3'd7)      wr_piece = B_QUEEN;
    else if (piece_q == W_PAWN && dst_q.y == 3'd0) wr_piece = W_QUEEN;
  end
`else
  assign wr_piece = piece_q;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cap_d   = cap_q;
    piece_d = piece_q;
    wait_d  = wait_q;
    src_d   = src_q;
    dst_d   = dst_q;

    case (state_q)
      S_IDLE: begin
        if (bus.init_req) begin
          state_d = S_INIT;
          addr_d  = 6'd0;
          data_d  = rom_piece;
          we_d    = 1'b1;
        end else if (bus.move_req) begin
          if (bad_move) begin
            err_d = 1'b1;
          end else begin
            src_d.x = bus.src_x[2:0];
            src_d.y = bus.src_y[2:0];
            dst_d.x = bus.dst_x[2:0];
            dst_d.y = bus.dst_y[2:0];
            addr_d  = sq_addr(src_d);
            wait_d  = 2'd0;
            state_d = S_RD_SRC;
          end
        end
      end

      S_INIT: begin
        if (addr_q == 6'd63) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + 6'd1;
          data_d = rom_piece;
          we_d   = 1'b1;
        end
      end

      // address has been stable since entry; rd_data is valid once the
      // wait count reaches the RAM latency
      S_RD_SRC: begin
        if (wait_q == RD_WAIT) begin
          if (bus.rd_data == EMPTY) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            piece_d = bus.rd_data;
            addr_d  = sq_addr(dst_q);
            wait_d  = 2'd0;
            state_d = S_RD_DST;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_RD_DST: begin
        if (wait_q == RD_WAIT) begin
          cap_d   = bus.rd_data;
          addr_d  = sq_addr(dst_q);
          data_d  = wr_piece;
          we_d    = 1'b1;
          state_d = S_WR_DST;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      S_WR_DST: begin
        addr_d  = sq_addr(src_q);
        data_d  = EMPTY;
        we_d    = 1'b1;
        state_d = S_WR_SRC;
      end

      S_WR_SRC: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cap_q   <= '0;
      piece_q <= '0;
      wait_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cap_q   <= cap_d;
      piece_q <= piece_d;
      wait_q  <= wait_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  assign bus.address  = addr_q;
  assign bus.data_out = data_q;
  assign bus.write_en = we_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = err_q;
  assign bus.captured = cap_q;

endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer with a 1-cycle synchronous RAM model.
module tb_board_writer;

`ifdef PROMOTION_EN
  localparam int PROMO_DATA = 5;
`else
  localparam int PROMO_DATA = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  board_writer_if bus ();

  board_writer #(.MEM_RD_LAT(1)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // RAM model with preload port and a log of every write seen
  logic [3:0] mem [0:63];
  logic       pl_en;
  logic [5:0] pl_a;
  logic [3:0] pl_d;
  int         wn = 0;
  int         wla [0:1023];
  int         wld [0:1023];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (bus.write_en) begin
      mem[bus.address] <= bus.data_out;
      wla[wn] <= int'(bus.address);
      wld[wn] <= int'(bus.data_out);
      wn <= wn + 1;
    end
    bus.rd_data <= mem[bus.address];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_address"},  int'(bus.address),  0);
    chk({tag, "_data_out"}, int'(bus.data_out), 0);
    chk({tag, "_write_en"}, int'(bus.write_en), 0);
    chk({tag, "_busy"},     int'(bus.busy),     0);
    chk({tag, "_done"},     int'(bus.done),     0);
    chk({tag, "_captured"}, int'(bus.captured), 0);
    chk({tag, "_error"},    int'(bus.error),    0);
  endtask

  // Starts init; optionally pokes a move_req mid-fill. Returns edges from
  // acceptance to done (64 expected) and whether error was ever seen.
  task automatic run_init(input bit poke_move, output int n, output bit err_seen);
    bus.init_req = 1'b1;
    @(posedge clk); #1;
    bus.init_req = 1'b0;
    bus.move_req = 1'b0;
    n = 0;
    err_seen = bus.error;
    while (!bus.done && n < 200) begin
      if (poke_move && n == 10) begin
        bus.src_x = 4'd4; bus.src_y = 4'd6; bus.dst_x = 4'd4; bus.dst_y = 4'd4;
        bus.move_req = 1'b1;
      end
      if (n == 12) bus.move_req = 1'b0;
      @(posedge clk); #1;
      n++;
      if (bus.error) err_seen = 1'b1;
    end
    bus.move_req = 1'b0;
  endtask

  // Issues one move request, scrambles the coordinate inputs right after
  // acceptance, and waits for done or error.
  task automatic do_move(input logic [3:0] sx, sy, dx, dy,
                         output bit e, output bit d, output int n);
    bus.src_x = sx; bus.src_y = sy; bus.dst_x = dx; bus.dst_y = dy;
    bus.move_req = 1'b1;
    @(posedge clk); #1;
    bus.move_req = 1'b0;
    bus.src_x = 4'd7; bus.src_y = 4'd0; bus.dst_x = 4'd0; bus.dst_y = 4'd7;
    n = 0;
    e = bus.error;
    d = bus.done;
    while (!e && !d && n < 50) begin
      @(posedge clk); #1;
      n++;
      e = bus.error;
      d = bus.done;
    end
  endtask

  typedef struct {
    int addr;
    int exp;
  } ini_t;

  typedef struct {
    bit         pl;
    logic [5:0] pa0; logic [3:0] pd0;
    logic [5:0] pa1; logic [3:0] pd1;
    logic [3:0] sx, sy, dx, dy;
    bit         exp_err;
    int         exp_cap;
    int         nwr;
    int         wa0, wd0, wa1, wd1;
  } mv_t;

  ini_t ini [8];
  mv_t  mv  [6];

  initial begin
    int  n, w0;
    bit  e, d;

    ini[0] = '{0, 4};   ini[1] = '{4, 6};   ini[2] = '{12, 1};  ini[3] = '{35, 0};
    ini[4] = '{52, 7};  ini[5] = '{60, 12}; ini[6] = '{3, 5};   ini[7] = '{63, 10};

    //       pl  pa0 pd0 pa1 pd1  sx sy dx dy err cap nwr wa0 wd0 wa1 wd1
    mv[0] = '{0, 0,  0,  0,  0,   4, 6, 4, 4, 0,  0,  2,  36, 7,  52, 0};
    mv[1] = '{1, 20, 9,  11, 1,   4, 2, 3, 1, 0,  1,  2,  11, 9,  20, 0};
    mv[2] = '{0, 0,  0,  0,  0,   0, 3, 0, 4, 1,  1,  0,  0,  0,  0,  0};
    mv[3] = '{0, 0,  0,  0,  0,   2, 2, 2, 2, 1,  1,  0,  0,  0,  0,  0};
    mv[4] = '{0, 0,  0,  0,  0,   1, 1, 9, 1, 1,  1,  0,  0,  0,  0,  0};
    mv[5] = '{1, 49, 1,  49, 1,   1, 6, 1, 7, 0,  8,  2,  57, PROMO_DATA, 49, 0};

    rst_n = 1'b0;
    bus.init_req = 1'b0; bus.move_req = 1'b0;
    bus.src_x = '0; bus.src_y = '0; bus.dst_x = '0; bus.dst_y = '0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    for (int i = 0; i < 64; i++) mem[i] = 4'd0;
    repeat (3) @(posedge clk); #1;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // init and move requested together: init wins; a mid-fill move is ignored
    bus.src_x = 4'd4; bus.src_y = 4'd6; bus.dst_x = 4'd4; bus.dst_y = 4'd4;
    bus.move_req = 1'b1;
    w0 = wn;
    run_init(1'b1, n, e);
    chk("init_done_latency", n, 64);
    chk("init_write_count", wn - w0, 64);
    chk("init_no_error", int'(e), 0);
    @(posedge clk); #1;
    chk("init_busy_after_done", int'(bus.busy), 0);
    chk("init_done_single", int'(bus.done), 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("init_mem[%0d]", ini[i].addr), int'(mem[ini[i].addr]), ini[i].exp);

    // reset in the middle of a fill
    bus.init_req = 1'b1;
    @(posedge clk); #1;
    bus.init_req = 1'b0;
    n = 0;
    while (bus.address != 6'd30 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midreset_reached_30", int'(bus.address), 30);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    w0 = wn;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("midreset_no_writes", wn - w0, 0);
    chk("midreset_idle", int'(bus.busy), 0);

    // clean fill, then the move table
    run_init(1'b0, n, e);
    chk("reinit_done_latency", n, 64);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      if (mv[i].pl) begin
        pl_en = 1'b1; pl_a = mv[i].pa0; pl_d = mv[i].pd0;
        @(posedge clk); #1;
        pl_a = mv[i].pa1; pl_d = mv[i].pd1;
        @(posedge clk); #1;
        pl_en = 1'b0;
      end
      w0 = wn;
      do_move(mv[i].sx, mv[i].sy, mv[i].dx, mv[i].dy, e, d, n);
      chk($sformatf("mv%0d_error", i), int'(e), int'(mv[i].exp_err));
      chk($sformatf("mv%0d_done", i), int'(d), int'(!mv[i].exp_err));
      chk($sformatf("mv%0d_captured", i), int'(bus.captured), mv[i].exp_cap);
      chk($sformatf("mv%0d_writes", i), wn - w0, mv[i].nwr);
      if (!mv[i].exp_err) begin
        // 6 edges after acceptance = 7 cycles counting the request cycle
        chk($sformatf("mv%0d_latency", i), n, 6);
        chk($sformatf("mv%0d_w0_addr", i), wla[w0],     mv[i].wa0);
        chk($sformatf("mv%0d_w0_data", i), wld[w0],     mv[i].wd0);
        chk($sformatf("mv%0d_w1_addr", i), wla[w0 + 1], mv[i].wa1);
        chk($sformatf("mv%0d_w1_data", i), wld[w0 + 1], mv[i].wd1);
        chk($sformatf("mv%0d_mem_dst", i), int'(mem[mv[i].wa0]), mv[i].wd0);
        chk($sformatf("mv%0d_mem_src", i), int'(mem[mv[i].wa1]), 0);
      end
      @(posedge clk); #1;
      chk($sformatf("mv%0d_idle", i), int'(bus.busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_writer.md
Name: board_writer

Overview:
- Write-side engine for the 64-square board memory; the counterpart to the control and validator read ports.
- Two jobs:
  - Fills the memory with the standard starting position.
  - Commits a move in read-modify-write form: read the source, read the destination, write the piece to the destination, then clear the source.
- Drives the datapath port of memory_access (address, data, write enable).
- Reports the captured piece and completion back to control.

Parameters:
- MEM_RD_LAT, default 1: clock cycles from address change to valid rd_data (synchronous RAM). Legal values are 1 and 2.

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- reset  in  1  asynchronous, active-low reset.
- init_req  in  1  level or pulse; sampled in IDLE; starts the board fill.
- move_req  in  1  sampled in IDLE; starts a move commit.
- src_x, src_y  in  4 each  source square.
- dst_x, dst_y  in  4 each  destination square.
- rd_data  in  4  piece code read from memory at address.
- address  out  6  memory address, {y[2:0], x[2:0]}, same mapping as address_encoder.
- data_out  out  4  piece code to write.
- write_en  out  1  memory write strobe, one cycle per write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- captured  out  4  piece found on the destination before the last move; 0 means empty.
- error  out  1  one-cycle pulse when a move is rejected.

Behaviour:
- Reset values: address=0, data_out=0, write_en=0, busy=0, done=0, captured=0, error=0, state=IDLE.
- Piece codes: 0 empty; black 1–6 (P N B R Q K); white 7–12 (P N B R Q K).
- Request sampling:
  - Requests are sampled only in IDLE.
  - init_req has priority over move_req when both are high.
  - Requests arriving while busy are ignored, not queued.
- INIT:
  - A 6-bit counter runs 0..63 with one write per cycle: address=counter, write_en=1.
  - Contents by rank y=counter[5:3], file x=counter[2:0]:
    - y=0: black back rank R N B Q K B N R = 4 2 3 5 6 3 2 4.
    - y=1: all 1.
    - y=2..5: all 0.
    - y=6: all 7.
    - y=7: white back rank 10 8 9 11 12 9 8 10.
  - After writing address 63: go to DONE. INIT takes exactly 64 cycles.
- MOVE, entry check in IDLE:
  - If src_x/src_y/dst_x/dst_y >7, or src==dst: pulse error, stay IDLE, no writes.
  - Otherwise latch all four coordinates, so later input changes have no effect.
- MOVE sequence:
  - RD_SRC: address=src, then wait MEM_RD_LAT cycles; latch rd_data as piece.
  - If piece==0: pulse error, return to IDLE, no writes, captured unchanged.
  - RD_DST: address=dst, then wait MEM_RD_LAT cycles; latch rd_data into captured.
  - WR_DST: address=dst, data_out=piece, write_en=1.
  - WR_SRC: address=src, data_out=0, write_en=1.
  - Then DONE.
  - Total with MEM_RD_LAT=1 is 7 cycles from request to done pulse.
- DONE: done=1 for one cycle, busy=1 during it; next cycle IDLE with busy=0.
- write_en is asserted only in INIT, WR_DST and WR_SRC.
- Reset mid-operation:
  - Asynchronous return to IDLE; outputs go to their reset values immediately.
  - A partially filled or partially moved board is left as is; control must re-issue init.
- No capture-colour legality checking here; that belongs to the validator.

Optional Feature:
- PROMOTION_EN defined:
  - In WR_DST, a piece of 1 landing on y=7 is written as 5.
  - A piece of 7 landing on y=0 is written as 11.
  - captured is unaffected.
- Undefined: the piece is written unchanged.

Decomposition:
- Shared package chess_pkg:
  - Piece code constants (EMPTY, B_PAWN..W_KING).
  - State encoding localparams.
  - BOARD_W=8.
  - Address-mapping function {y,x}.
- One natural sub-module: init_rom. It is combinational, maps a 6-bit address to the 4-bit starting piece, and is reusable by a VGA test pattern.

Test Plan:
- Init: reset low→high, init_req=1 for 1 cycle.
  - 64 consecutive write_en cycles.
  - addr 0→4, 4→6, 12→1, 35→0, 52→7, 60→12.
  - done pulses 64 cycles after acceptance; busy drops the next cycle.
- Move: after init, move src(4,6)→dst(4,4).
  - Writes addr 36←7 then addr 52←0.
  - captured=0, done at cycle 7.
- Capture: memory preloaded so addr 20=9 and addr 11=1; move (4,2)→(3,1).
  - captured=1, addr 11←9, addr 20←0.
- Rejects, each with error pulse, zero write_en, and captured unchanged:
  - Move from empty square (0,3).
  - src=dst=(2,2).
  - dst_x=9.
- Priority and reset:
  - init_req and move_req high together in IDLE: init runs.
  - move_req during INIT: ignored.
  - Assert reset at INIT count 30: outputs go to 0 immediately, state is IDLE, and no further writes.
- PROMOTION_EN: addr 49=1, move (1,6)→(1,7).
  - Feature defined: addr 57 receives 5.
  - Feature undefined: addr 57 receives 1.
